nrzi_rx_deserializer: RTL
=========================

Name: nrzi_rx_deserializer

Overview:
Parametrised USB receive-path block that sits between the line-state sampler/DPLL and the UTMI RX data path.
- Per bit strobe: NRZI-decodes the sampled J level, removes stuffed bits with a configurable run length, and detects stuffing errors and SE0 end-of-packet.
- Assembles decoded bits LSB-first into DATA_W-bit words and presents them on a valid/ready holding register.
- Flags overflow and non-aligned EOP.

Parameters:
- DATA_W, 8, word width assembled from decoded bits (2..16).
- STUFF_LEN, 6, consecutive decoded ones after which the next bit is a stuff bit (2..15).
- CNT_W, 4, width of the ones counter and bit index; must satisfy 2^CNT_W > max(STUFF_LEN, DATA_W).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- sample  in  1  one-CLK strobe marking a valid bit sample; all line logic advances only when sample=1.
- J  in  1  synchronised line level (1=J).
- se0  in  1  line is SE0 at this sample.
- rx_active  in  1  packet in progress (after SYNC detect); 0 = idle.
- data_out  out  DATA_W  assembled word, LSB = first received bit.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts data_out when data_valid=1 at the CLK edge.
- stuff_err  out  1  sticky stuffing error for the current packet.
- eop  out  1  one-CLK pulse on SE0 during rx_active.
- align_err  out  1  one-CLK pulse with eop when a partial word was pending.
- overflow  out  1  one-CLK pulse when a word completes while data_valid=1 and data_ready=0.

Behaviour:
- Reset values:
  - data_out=0, data_valid=0, stuff_err=0, eop=0, align_err=0, overflow=0.
  - Internal: last=1 (J idle), ones_cnt=0, bit_idx=0, shift register=0.
- Priority on a sample cycle: RST > !rx_active > se0 > data bit. eop, align_err and overflow are 0 on every cycle they are not explicitly pulsed.
- Idle (sample & !rx_active):
  - last<=J; ones_cnt<=0; bit_idx<=0; stuff_err<=0.
  - data_valid/data_out are untouched; a pending word stays until consumed.
- Decode: bit = ~(J ^ last); last<=J on every sample during rx_active, including stuff bits and SE0 samples.
- Stuff bit: a sample with ones_cnt==STUFF_LEN is a stuff bit.
  - bit=0: discarded, ones_cnt<=0, bit_idx unchanged.
  - bit=1: stuff_err<=1 (sticky until the next idle sample); all further word assembly in the packet is suppressed.
- Normal bit:
  - Shift register <= {bit, sr[DATA_W-1:1]}.
  - ones_cnt<=bit ? ones_cnt+1 : 0.
  - bit_idx<=bit_idx+1, wrapping to 0 after DATA_W-1.
- Word complete (normal bit with bit_idx==DATA_W-1, stuff_err=0):
  - data_out<={bit, sr[DATA_W-1:1]}; data_valid<=1 on the same edge.
  - Latency: one CLK after the final sample.
- Handshake: data_valid & data_ready at an edge clears data_valid, unless a word completes on that same edge; in that case data_valid stays 1 with the new data and overflow=0.
- Overflow: a word completes while data_valid=1 and data_ready=0 → new word overwrites data_out, data_valid stays 1, overflow pulses for 1 CLK.
- SE0 during rx_active:
  - eop pulses.
  - align_err pulses if bit_idx!=0 and stuff_err=0.
  - bit_idx<=0, ones_cnt<=0; no word is emitted.
  - Further se0 samples re-pulse eop only if bit_idx!=0 (i.e. one eop per SE0 run).
- sample=0: no line state change; only the handshake logic runs.
- Reset mid-packet: all state returns to reset values immediately (asynchronous); a pending word is lost.

Decomposition:
- Package nrzi_rx_pkg: default DATA_W/STUFF_LEN constants, a line-state enumeration (J, K, SE0), and the CNT_W derivation function (clog2-based).
- Sub-module nrzi_bit_unstuff: NRZI decode, ones counter, stuff detection and stuff_err. Outputs bit_vld, bit, eop_raw per sample.
- Top level: shift register, bit_idx, holding register, handshake, overflow and align_err.

Test Plan:
- Defaults, last=1, data_ready=1, rx_active=1, J samples 0,1,0,1,0,1,0,0 → data_out=0x80, one data_valid cycle one CLK after the 8th sample, no errors.
- J held constant for 6 samples, toggled once, held for 2 → data_out=0xFF after the 9th sample; stuff bit dropped; stuff_err=0.
- 7 consecutive non-transition samples → stuff_err=1 at the 7th sample; no data_valid for the rest of the packet; cleared by the first idle sample after rx_active=0.
- data_ready=0, two full words received → second word overwrites data_out, overflow=1 for exactly 1 CLK, data_valid stays 1; asserting data_ready for one edge then clears data_valid.
- 3 data bits then se0=1 for 2 samples → eop=1 and align_err=1 for exactly one CLK; no data_valid; bit_idx back at 0, so the next packet's first byte aligns correctly.
- STUFF_LEN=3, DATA_W=4: J constant for 3 samples, toggled, constant for 1 → data_out=0xF after the 5th sample; RST asserted mid-word → all outputs 0 immediately.

Source files
------------

// File: rtl/nrzi_rx_deserializer_pkg.sv
// Shared constants, line-state encoding and counter-width helper for the NRZI RX path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nrzi_rx_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_STUFF_LEN = 6;

  // Classified line level at a bit sample.
  typedef enum logic [1:0] {
    LINE_J   = 2'd0,
    LINE_K   = 2'd1,
    LINE_SE0 = 2'd2
  } line_state_t;

  // Counter width able to hold both the ones run (up to stuff_len) and the
  // bit index (up to data_w-1): 2^w must exceed the larger of the two.
  function automatic int nrzi_cnt_w(input int data_w, input int stuff_len);
    int m;
    m = (data_w > stuff_len) ? data_w : stuff_len;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nrzi_rx_deserializer_if.sv
// Word/status bus between the deserializer and the UTMI RX consumer.
// Latency: n/a (wiring only).
// Backpressure: data_ready from the consumer; producer overwrites on overflow.
//   master: drives data_out, data_valid, stuff_err, eop, align_err, overflow; reads data_ready.
//   slave : the mirror image.
interface nrzi_rx_deserializer_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              stuff_err;
  logic              eop;
  logic              align_err;
  logic              overflow;

  modport master (
    output data_out, data_valid, stuff_err, eop, align_err, overflow,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, stuff_err, eop, align_err, overflow,
    output data_ready
  );
endinterface

// File: rtl/nrzi_rx_deserializer_unstuff.sv
// NRZI decode, ones-run counting, stuff-bit removal and sticky stuffing error.
// Latency: bit_vld/bit_val/eop_raw are combinational on the sample cycle; stuff_err registered.
// Backpressure: none; advances on every sample strobe.
//   in : CLK, RST (async active-low), sample, J, se0, rx_active
//   out: bit_vld (decoded data bit this sample), bit_val, eop_raw (first SE0 of a run), stuff_err
module nrzi_bit_unstuff
  import nrzi_rx_pkg::*;
#(
  parameter int STUFF_LEN = DEF_STUFF_LEN,
  parameter int CNT_W     = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic sample,
  input  logic J,
  input  logic se0,
  input  logic rx_active,
  output logic bit_vld,
  output logic bit_val,
  output logic eop_raw,
  output logic stuff_err
);

  logic             last;
  logic             se0_run;
  logic [CNT_W-1:0] ones_cnt;
  line_state_t      line;
  logic             dec;
  logic             at_stuff;

  always_comb begin
    line = LINE_K;
    if (se0) begin
      line = LINE_SE0;
    end else if (J) begin
      line = LINE_J;
    end
    dec      = ~(J ^ last);
    at_stuff = (ones_cnt == CNT_W'(STUFF_LEN));
    bit_vld  = 1'b0;
    bit_val  = dec;
    eop_raw  = 1'b0;
    if (sample && rx_active) begin
      case (line)
        // Only the first SE0 sample of a run reports end of packet.
        LINE_SE0: eop_raw = ~se0_run;
        default:  bit_vld = ~at_stuff;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last      <= 1'b1;
      se0_run   <= 1'b0;
      ones_cnt  <= '0;
      stuff_err <= 1'b0;
    end else if (sample) begin
      // The reference level follows the line on every sample, stuff bits and SE0 included.
      last <= J;
      if (!rx_active) begin
        ones_cnt  <= '0;
        stuff_err <= 1'b0;
        se0_run   <= 1'b0;
      end else if (line == LINE_SE0) begin
        ones_cnt <= '0;
        se0_run  <= 1'b1;
      end else begin
        se0_run <= 1'b0;
        if (at_stuff) begin
          // A stuff position must decode as 0; a 1 here is a framing violation.
          ones_cnt <= '0;
          if (dec) begin
            stuff_err <= 1'b1;
          end
        end else begin
          ones_cnt <= dec ? ones_cnt + 1'b1 : '0;
        end
      end
    end
  end

endmodule

// File: rtl/nrzi_rx_deserializer.sv
// USB RX deserializer: unstuffed NRZI bits assembled LSB-first into words on a holding register.
// Latency: word presented one CLK after its final bit sample.
// Backpressure: valid/ready; a word completing while the holder is full overwrites it and pulses overflow.
//   in : CLK, RST (async active-low), sample, J, se0, rx_active
//   rx : master side of nrzi_rx_deserializer_if (data_out/data_valid/data_ready + status pulses)
module nrzi_rx_deserializer
  import nrzi_rx_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int STUFF_LEN = DEF_STUFF_LEN,
  parameter int CNT_W     = nrzi_cnt_w(DEF_DATA_W, DEF_STUFF_LEN)
) (
  input  logic CLK,
  input  logic RST,
  input  logic sample,
  input  logic J,
  input  logic se0,
  input  logic rx_active,
  nrzi_rx_deserializer_if.master rx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  logic              bit_vld;
  logic              bit_val;
  logic              eop_raw;
  logic              stuff_err;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] word_next;
  logic [CNT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              eop_q;
  logic              align_q;
  logic              ovf_q;
  logic              word_done;
  logic              se0_cycle;

  nrzi_bit_unstuff #(
    .STUFF_LEN (STUFF_LEN),
    .CNT_W     (CNT_W)
  ) u_unstuff (
    .CLK       (CLK),
    .RST       (RST),
    .sample    (sample),
    .J         (J),
    .se0       (se0),
    .rx_active (rx_active),
    .bit_vld   (bit_vld),
    .bit_val   (bit_val),
    .eop_raw   (eop_raw),
    .stuff_err (stuff_err)
  );

  assign word_next = {bit_val, sr[DATA_W-1:1]};
  // After a stuffing error the index keeps counting but no word is ever released.
  assign word_done = bit_vld && !stuff_err && (bit_idx == LAST_IDX);
  assign se0_cycle = sample && rx_active && se0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sr      <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      eop_q   <= 1'b0;
      align_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      eop_q   <= 1'b0;
      align_q <= 1'b0;
      ovf_q   <= 1'b0;

      if (sample && !rx_active) begin
        bit_idx <= '0;
      end else if (se0_cycle) begin
        bit_idx <= '0;
        eop_q   <= eop_raw;
        align_q <= eop_raw && (bit_idx != '0) && !stuff_err;
      end else if (bit_vld) begin
        sr      <= word_next;
        bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
      end

      // A completing word wins over a same-edge consume, so valid stays high.
      if (word_done) begin
        data_q  <= word_next;
        valid_q <= 1'b1;
        ovf_q   <= valid_q && !rx.data_ready;
      end else if (valid_q && rx.data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = valid_q;
  assign rx.stuff_err  = stuff_err;
  assign rx.eop        = eop_q;
  assign rx.align_err  = align_q;
  assign rx.overflow   = ovf_q;

endmodule
